// File: rtl/sqrt_result_bcd.sv
// sqrt_result_bcd: captures roots leaving the pipelined square-root stage,
// converts each to packed BCD with a serial double-dabble engine and drives
// a multiplexed, active-high 7-segment display with the latest result.
module sqrt_result_bcd #(
   parameter int G_WIDTH    = 8,
   parameter int G_DIGITS   = 2,
   parameter int G_SCAN_DIV = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [G_WIDTH/2-1:0]    root,
   output logic                    busy,
   output logic [4*G_DIGITS-1:0]   bcd_out,
   output logic                    bcd_valid,
   output logic                    overrun,
   output logic [6:0]              seg,
   output logic [G_DIGITS-1:0]     digit_sel
);

   localparam int W      = G_WIDTH / 2;
   localparam int CNT_W  = $clog2(W + 1);
   localparam int SCAN_W = (G_SCAN_DIV > 1) ? $clog2(G_SCAN_DIV) : 1;
   localparam int IDX_W  = (G_DIGITS > 1) ? $clog2(G_DIGITS) : 1;
   localparam int ACC_W  = 4 * G_DIGITS;

   // Decimal digits needed to print the largest W-bit root.
   function automatic int min_digits(input int w);
      longint unsigned max_v;
      int n;
      max_v = (64'd1 << w) - 64'd1;
      n = 0;
      do begin
         n++;
         max_v = max_v / 10;
      end while (max_v != 0);
      return n;
   endfunction

   if ((G_WIDTH % 2) != 0 || G_WIDTH < 2) begin : g_bad_width
      $error("G_WIDTH must be even and at least 2");
   end
   if (G_DIGITS < min_digits(W)) begin : g_bad_digits
      $error("G_DIGITS too small to hold the largest root");
   end
   if (G_SCAN_DIV < 1) begin : g_bad_scan
      $error("G_SCAN_DIV must be at least 1");
   end

   typedef enum logic {S_IDLE, S_CONV} state_t;

   // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal codes blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [W-1:0]        valid_q, valid_d;
   logic [W-1:0]        shreg_q, shreg_d;
   logic [ACC_W-1:0]    acc_q, acc_d, acc_adj;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ACC_W-1:0]    bcd_out_q, bcd_out_d;
   logic                bcd_valid_q, bcd_valid_d;
   logic                overrun_q, overrun_d;
   logic [SCAN_W-1:0]   scan_q, scan_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [G_DIGITS-1:0] sel_q, sel_d;
   logic [6:0]          seg_q, seg_d;
   logic                tap;
   logic                wrap;

   // Tag leaves the tracker exactly when its root is on the root input.
   assign tap = valid_q[W-1];

   // Conversion FSM and double-dabble datapath: next-state logic.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      state_d     = state_q;
      valid_d     = (valid_q << 1) | W'(in_valid);
      shreg_d     = shreg_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      bcd_out_d   = bcd_out_q;
      bcd_valid_d = 1'b0;
      overrun_d   = overrun_q;

      acc_adj = acc_q;
      for (int d = 0; d < G_DIGITS; d++) begin
         if (acc_q[4*d +: 4] >= 4'd5) begin
            acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (tap) begin
               shreg_d = root;
               acc_d   = '0;
               cnt_d   = CNT_W'(W);
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            {acc_d, shreg_d} = {acc_adj, shreg_q} << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (tap) begin
               overrun_d = 1'b1;
            end
            if (cnt_q == CNT_W'(1)) begin
               bcd_out_d   = acc_d;
               bcd_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Conversion FSM and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (rst) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         shreg_q     <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         bcd_out_q   <= '0;
         bcd_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         shreg_q     <= shreg_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         bcd_out_q   <= bcd_out_d;
         bcd_valid_q <= bcd_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   // Display scan: rotate the digit enable on wrap, decode the digit it will select.
   always_comb begin
      wrap   = (scan_q == SCAN_W'(G_SCAN_DIV - 1));
      scan_d = wrap ? '0 : scan_q + SCAN_W'(1);
      sel_d  = sel_q;
      idx_d  = idx_q;
      if (wrap) begin
         sel_d = (sel_q << 1) | (sel_q >> (G_DIGITS - 1));
         idx_d = (idx_q == IDX_W'(G_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      seg_d = seg_decode(bcd_out_q[4*int'(idx_d) +: 4]);
   end

   // Display registers: seg and digit_sel update together so they never disagree.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q <= '0;
         idx_q  <= '0;
         sel_q  <= G_DIGITS'(1);
         seg_q  <= 7'h3F;
      end else begin
         scan_q <= scan_d;
         idx_q  <= idx_d;
         sel_q  <= sel_d;
         seg_q  <= seg_d;
      end
   end

   assign busy      = (state_q == S_CONV);
   assign bcd_out   = bcd_out_q;
   assign bcd_valid = bcd_valid_q;
   assign overrun   = overrun_q;
   assign seg       = seg_q;
   assign digit_sel = sel_q;

endmodule

// File: tb/tb_sqrt_result_bcd.sv
// Bench for sqrt_result_bcd: table of roots with hand-computed BCD and
// segment codes, plus sequences for spacing, overrun and mid-conversion reset.
module tb_sqrt_result_bcd;

   localparam int G_WIDTH    = 8;
   localparam int W          = 4;
   localparam int G_DIGITS   = 2;
   localparam int G_SCAN_DIV = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic [W-1:0]          root;
   logic                  busy;
   logic [4*G_DIGITS-1:0] bcd_out;
   logic                  bcd_valid;
   logic                  overrun;
   logic [6:0]            seg;
   logic [G_DIGITS-1:0]   digit_sel;

   sqrt_result_bcd #(
      .G_WIDTH   (G_WIDTH),
      .G_DIGITS  (G_DIGITS),
      .G_SCAN_DIV(G_SCAN_DIV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .root     (root),
      .busy     (busy),
      .bcd_out  (bcd_out),
      .bcd_valid(bcd_valid),
      .overrun  (overrun),
      .seg      (seg),
      .digit_sel(digit_sel)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] root;
      logic [7:0] bcd;
      logic [6:0] seg0;
      logic [6:0] seg1;
   } vec_t;

   vec_t       vecs[12];
   int         total = 0;
   int         bad   = 0;
   logic [7:0] prev_bcd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One conversion: in_valid at cycle 0, root valid only at cycle 4.
   task automatic run_conv(input logic [3:0] r, input logic [7:0] exp_bcd, input string tag);
      logic [12:0] busy_v;
      logic [12:0] valid_v;
      logic [7:0]  got;
      logic        ov;
      bit          stable;
      stable = 1'b1;
      got    = '0;
      ov     = 1'b0;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         busy_v[c]  = busy;
         valid_v[c] = bcd_valid;
         if (c == 9)  got = bcd_out;
         if (c == 12) ov = overrun;
         if (c < 9 && bcd_out !== prev_bcd) stable = 1'b0;
         in_valid = (c == 0);
         root     = (c == 4) ? r : ~r;
      end
      check({tag, " busy"}, 32'(busy_v), 32'h1E0);
      check({tag, " bcd_valid"}, 32'(valid_v), 32'h200);
      check({tag, " bcd_out"}, 32'(got), 32'(exp_bcd));
      check({tag, " stable"}, 32'(stable), 32'd1);
      check({tag, " overrun"}, 32'(ov), 32'd0);
      prev_bcd = exp_bcd;
   endtask

   // Watch the display for 8 cycles; each selected digit must show its code.
   task automatic observe_display(input logic [6:0] s0, input logic [6:0] s1, input string tag);
      int err;
      bit seen0;
      bit seen1;
      err   = 0;
      seen0 = 1'b0;
      seen1 = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         case (digit_sel)
            2'b01: begin seen0 = 1'b1; if (seg !== s0) err++; end
            2'b10: begin seen1 = 1'b1; if (seg !== s1) err++; end
            default: err++;
         endcase
      end
      check({tag, " seg errors"}, 32'(err), 32'd0);
      check({tag, " digits seen"}, 32'({seen1, seen0}), 32'd3);
   endtask

   initial begin
      logic [18:0] vv;
      logic [15:0] ov_v;
      logic [8:0]  bz;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic        ov;

      vecs[0]  = '{4'd15, 8'h15, 7'h6D, 7'h06};
      vecs[1]  = '{4'd0,  8'h00, 7'h3F, 7'h3F};
      vecs[2]  = '{4'd9,  8'h09, 7'h6F, 7'h3F};
      vecs[3]  = '{4'd12, 8'h12, 7'h5B, 7'h06};
      vecs[4]  = '{4'd7,  8'h07, 7'h07, 7'h3F};
      vecs[5]  = '{4'd10, 8'h10, 7'h3F, 7'h06};
      vecs[6]  = '{4'd8,  8'h08, 7'h7F, 7'h3F};
      vecs[7]  = '{4'd4,  8'h04, 7'h66, 7'h3F};
      vecs[8]  = '{4'd3,  8'h03, 7'h4F, 7'h3F};
      vecs[9]  = '{4'd6,  8'h06, 7'h7D, 7'h3F};
      vecs[10] = '{4'd13, 8'h13, 7'h4F, 7'h06};
      vecs[11] = '{4'd14, 8'h14, 7'h66, 7'h06};

      rst      = 1'b1;
      in_valid = 1'b0;
      root     = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset bcd_valid", 32'(bcd_valid), 32'd0);
      check("reset bcd_out", 32'(bcd_out), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      check("reset digit_sel", 32'(digit_sel), 32'd1);
      check("reset seg", 32'(seg), 32'h3F);
      rst      = 1'b0;
      prev_bcd = 8'h00;

      for (int i = 0; i < 12; i++) begin
         run_conv(vecs[i].root, vecs[i].bcd, $sformatf("vec%0d", i));
         observe_display(vecs[i].seg0, vecs[i].seg1, $sformatf("vec%0d", i));
      end

      // Pulses W+1 cycles apart: both converted, no overrun.
      b1 = '0; b2 = '0; ov = 1'b0;
      for (int c = 0; c < 19; c++) begin
         @(negedge clk);
         vv[c] = bcd_valid;
         if (c == 10) b1 = bcd_out;
         if (c == 15) b2 = bcd_out;
         if (c == 18) ov = overrun;
         in_valid = (c == 0 || c == 5);
         root = (c == 4) ? 4'd9 : (c == 9) ? 4'd12 : 4'hF;
      end
      check("spaced bcd_valid", 32'(vv), 32'h4200);
      check("spaced first", 32'(b1), 32'h09);
      check("spaced second", 32'(b2), 32'h12);
      check("spaced overrun", 32'(ov), 32'd0);

      // Back-to-back pulses: second dropped, sticky overrun from cycle 6.
      b1 = '0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         ov_v[c] = overrun;
         vv[c]   = bcd_valid;
         if (c == 10) b1 = bcd_out;
         in_valid = (c <= 1);
         root = (c == 4) ? 4'd3 : (c == 5) ? 4'd6 : 4'hF;
      end
      check("overrun trace", 32'(ov_v), 32'hFFC0);
      check("overrun bcd_valid", 32'(vv[15:0]), 32'h0200);
      check("overrun bcd_out", 32'(b1), 32'h03);

      // Reset in cycle 6 of a conversion, with a second tag still in flight.
      vv = '0;
      bz = '0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         vv[c] = bcd_valid;
         if (c >= 7) bz[c-7] = busy;
         if (c == 7) begin
            check("mid rst busy", 32'(busy), 32'd0);
            check("mid rst bcd_valid", 32'(bcd_valid), 32'd0);
            check("mid rst bcd_out", 32'(bcd_out), 32'd0);
            check("mid rst overrun", 32'(overrun), 32'd0);
            check("mid rst digit_sel", 32'(digit_sel), 32'd1);
            check("mid rst seg", 32'(seg), 32'h3F);
         end
         if (c == 10) check("scan hold digit_sel", 32'(digit_sel), 32'd1);
         if (c == 11) begin
            check("scan switch digit_sel", 32'(digit_sel), 32'd2);
            check("scan switch seg", 32'(seg), 32'h3F);
         end
         in_valid = (c == 0 || c == 3);
         rst      = (c == 6);
         root = (c == 4) ? 4'd15 : (c == 7) ? 4'd9 : 4'hF;
      end
      check("mid rst no bcd_valid", 32'(vv[15:0]), 32'd0);
      check("mid rst idle after", 32'(bz), 32'd0);

      prev_bcd = 8'h00;
      run_conv(4'd15, 8'h15, "post_rst");
      observe_display(7'h6D, 7'h06, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sqrt_result_bcd.md
# sqrt_result_bcd

Downstream consumer of the pipelined integer square-root stage. It tracks operand validity through the root pipeline and captures each root as it emerges. It converts the root to packed BCD with a sequential shift-add-3 (double-dabble) engine and drives a multiplexed 7-segment display with the most recent result. It sits between the `sqrt` pipeline output and the chip output pins.

## Interface

Parameters:
- `G_WIDTH`, 8: operand width of the upstream sqrt stage; even. Root width `W = G_WIDTH/2`.
- `G_DIGITS`, 2: BCD digits. Must be ≥ ceil(W·log10 2); a smaller value is an elaboration error.
- `G_SCAN_DIV`, 1024: clock cycles each digit is displayed; ≥ 1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: high in the same cycle a valid operand is on the sqrt stage's `data_in`.
- `root`  in  `W`: the sqrt stage's `data_out`.
- `busy`  out  1: conversion in progress.
- `bcd_out`  out  `4*G_DIGITS`: last completed result; digit 0 (units) in bits [3:0].
- `bcd_valid`  out  1: one-cycle pulse when `bcd_out` updates.
- `overrun`  out  1: sticky; a valid root was dropped.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-high, registered.
- `digit_sel`  out  `G_DIGITS`: one-hot digit enable, active-high, registered.

## Operation

- Valid tracker: a `W`-deep shift register fed by `in_valid`. Its last stage, `tap`, is high exactly in the cycle `root` holds the root of the tagged operand (W edges after `in_valid`).
- FSM states: IDLE and CONV.
  - IDLE with `tap`=1: load `root` into a shift register, clear the BCD accumulator, set bit counter = W, go to CONV.
  - IDLE with `tap`=0: remain in IDLE.
  - CONV, each cycle: add 3 to every accumulator digit ≥ 5, then shift {accumulator, shift register} left 1. Decrement the counter.
  - CONV, counter reaching 0: this is the last CONV cycle. Register the accumulator result into `bcd_out`, pulse `bcd_valid`, go to IDLE.
- `busy` = (state == CONV).
- A `tap` arriving while in CONV, including the last CONV cycle, is dropped and sets `overrun`=1. `overrun` clears only on `rst`.
- Display: a scan counter wraps every `G_SCAN_DIV` cycles. On wrap, `digit_sel` rotates left (digit 0 → 1 → … → G_DIGITS-1 → 0).
  - `seg` is the decode of the `bcd_out` digit selected by the next `digit_sel` value, registered together with it so the two never mismatch.
- Decode: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F; codes A–F (unreachable)→00. No leading-zero blanking.
- A new `bcd_out` appears on `seg` at the next digit boundary, or earlier if that digit is already selected (decode is from live `bcd_out` each cycle).

## Timing

- Reset values: `busy`=0, `bcd_valid`=0, `bcd_out`=0, `overrun`=0, `digit_sel`=1 (digit 0), `seg`=7'h3F. The tracker, scan counter and FSM are cleared.
- `rst` mid-conversion abandons the conversion and clears the in-flight valid tags. No `bcd_valid` is produced for them.
- Latency: `in_valid` in cycle t gives `tap` in t+W, CONV in t+W+1 … t+2W, and `bcd_valid` in cycle t+2W+1 (= t+G_WIDTH+1).
- Throughput: one result per W+1 cycles. Two `in_valid` pulses spaced ≥ W+1 cycles are both converted; closer spacing drops the later one.
- `bcd_out` is stable between `bcd_valid` pulses.

## Test plan

- Defaults (G_WIDTH=8). Single `in_valid` at cycle 0 with root 15 presented at cycle 4 → `busy` high cycles 5–8; `bcd_valid` pulse in cycle 9 only; `bcd_out`=8'h15; `overrun`=0.
- Root 0 → `bcd_out`=8'h00. With G_SCAN_DIV=4, `seg`=7'h3F on both digits.
- `in_valid` in cycles 0 and 1 → only the first root is converted; `overrun`=1 from cycle 6 and held; a single `bcd_valid`.
- `in_valid` in cycles 0 and 5, roots 9 and 12 → `bcd_valid` in cycles 9 and 14; `bcd_out`=8'h09 then 8'h12; `overrun`=0.
- G_SCAN_DIV=4 after `bcd_out`=8'h15 → `digit_sel`/`seg` alternate 01/7'h6D and 10/7'h06, switching every 4 cycles.
- `rst` asserted in cycle 6 of a conversion → no `bcd_valid`; all outputs at reset values the cycle after; a later `in_valid` converts normally.
